uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
Receive-side counterpart of the 8N1 UART transmitter. It samples an asynchronous serial line and recovers 8-bit bytes, framed as 1 start bit, 8 data bits LSB first, no parity and 1 stop bit. Each good byte is presented for exactly one clock, and framing errors are flagged. It sits between the board RX pin and the byte consumer, and is the stage used in loopback against the transmitter.

Parameters:
CLKS_PER_BIT, 104, CLOCK cycles per bit (12 MHz / 115200); legal range ≥ 4; value is fixed at elaboration.
HALF_BIT, CLKS_PER_BIT/2 (integer divide), delay from start-edge detection to the start-bit centre sample.

Ports:
CLOCK      input   1  system clock; all logic on rising edge.
RESET      input   1  synchronous, active-high reset.
uart_rx    input   1  asynchronous serial line; idle high.
data       output  8  last correctly received byte; changes only when valid is asserted.
valid      output  1  one-cycle pulse: data holds a new good byte.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy       output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Interface: one clock, CLOCK; reset RESET is synchronous and active-high.
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops=1 (line treated as idle).
- RESET mid-frame abandons the frame with no valid or frame_err pulse. The first edge checked after reset is the next high→low transition.
- Input synchronizer:
  - uart_rx passes through 2 flops to produce rx_s.
  - Edge detection compares rx_s with a third flop holding its previous value.
  - Total input latency is 2 cycles.
- State machine:
  - IDLE: busy=0. A falling edge on rx_s (prev=1, now=0) → START, counter=0.
  - START: count to HALF_BIT-1, then sample rx_s.
    - rx_s=0 → DATA, counter=0, bit index=0.
    - rx_s=1 → IDLE (glitch rejected; no output pulse).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index], LSB first. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1: data<=shift register, valid=1 for the next cycle only → IDLE.
    - rx_s=0: frame_err=1 for the next cycle only; data unchanged → BREAK.
  - BREAK: busy=1. Wait for rx_s=1 (no edge needed) → IDLE. This prevents a low line being treated as a new start bit.
- Sample points, relative to the edge-detect cycle E:
  - start sample at E+HALF_BIT;
  - data bit k sample at E+HALF_BIT+(k+1)·CLKS_PER_BIT;
  - stop sample at E+HALF_BIT+9·CLKS_PER_BIT;
  - valid/frame_err at the stop sample +1 cycle.
- valid and frame_err are never high in the same cycle.
- No overrun handling: the consumer must take data on the valid cycle. data is held until the next good byte.
- Back-to-back frames: a start edge arriving directly after the stop bit is detected from IDLE. The stop sample at mid-bit leaves a half-bit margin.
- Counter width: $clog2(CLKS_PER_BIT); bit index is 3 bits. There is no wrap beyond the terminal count; the counter resets on each sample.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - DATA_BITS=8;
  - default CLKS_PER_BIT constant, also used by the transmitter.
- One natural sub-module: uart_sync_2ff, a parameterisable 2-flop synchronizer with a reset value, reusable for other async inputs such as switches.

Test Plan (CLKS_PER_BIT=16 for speed):
- Drive 0xA5 frame, 16 cycles/bit → exactly one valid pulse with data=8'hA5; frame_err stays 0; busy falls the cycle after valid.
- Glitch: uart_rx low for 4 cycles, then high → no valid/frame_err pulse; busy returns to 0 by HALF_BIT+4 cycles after the edge.
- Send 0x3C, then a frame 0x81 with stop bit 0 → frame_err pulse once, data stays 8'h3C; line held low for 40 cycles keeps busy=1; line goes high → IDLE; next frame 0x55 gives valid with data=8'h55.
- Back-to-back 0x00 then 0xFF, each with a single stop bit and no idle gap → two valid pulses, data 8'h00 then 8'hFF.
- Assert RESET for 1 cycle during data bit 3 of a frame → no pulse for that frame; data=8'h00; the following clean frame 0x7E is received correctly.
- Baud tolerance: frames 0xC3 at 15 and 17 cycles/bit → data=8'hC3 and valid in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer for asynchronous inputs with a reset value
module uart_sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver: start-edge detect, mid-bit sampling, framing check
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    // Idle-high reset value keeps a reset from looking like a start edge.
    uart_sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk      (CLOCK),
        .rst      (RESET),
        .async_in (uart_rx),
        .sync_out (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must go high before the next start edge counts.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - self-checking bench for uart_rx_8n1 at 16 clocks per bit
module tb_uart_rx_8n1;

    localparam int RX_CPB  = 16;
    localparam int RX_HALF = RX_CPB / 2;

    typedef struct {
        logic [7:0] b;
        int         cpb;
        logic       stop;
        int         gap;
        logic       good;
        logic [7:0] exp_d;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
        logic       busy_in;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    ev_t  ev_q[$];
    logic ba_q[$];
    logic pend_valid = 1'b0;
    logic prev_rst   = 1'b1;
    logic [7:0] prev_data = 8'h00;
    vec_t tbl[8];

    uart_rx_8n1 #(.CLKS_PER_BIT(RX_CPB)) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .uart_rx   (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line level x cycles after the start edge of a frame sent at cpb cycles per bit.
    function automatic logic line_at(input logic [7:0] b, input int cpb, input logic stop,
                                     input logic post, input int x);
        int j;
        j = x / cpb;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == 9) return stop;
        return post;
    endfunction

    // Receiver outcome {good, byte} from the nominal mid-bit sample offsets.
    function automatic logic [8:0] model_frame(input logic [7:0] b, input int cpb,
                                               input logic stop, input logic post);
        logic [7:0] r;
        logic       s;
        for (int k = 0; k < 8; k++) r[k] = line_at(b, cpb, stop, post, RX_HALF + (k + 1) * RX_CPB);
        s = line_at(b, cpb, stop, post, RX_HALF + 9 * RX_CPB);
        return {s, r};
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop, input int rst_j);
        logic v;
        for (int j = 0; j < 10; j++) begin
            if (j == 0) v = 1'b0;
            else if (j == 9) v = stop;
            else v = b[j-1];
            for (int c = 0; c < cpb; c++) begin
                rx  = v;
                rst = (j == rst_j) && (c == cpb / 2);
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
    endtask

    task automatic check_frame(input string nm, input logic good, input logic [7:0] exp_d);
        ev_t e;
        chk({nm, ".events"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk({nm, ".is_err"}, e.is_err, !good);
            chk({nm, ".busy_in_pulse"}, e.busy_in, 1);
            if (good) chk({nm, ".pulse_data"}, e.d, exp_d);
        end
        if (good) chk({nm, ".busy_after"}, (ba_q.size() > 0) ? int'(ba_q[0]) : 1, 0);
        chk({nm, ".data"}, data, exp_d);
        ev_q.delete();
        ba_q.delete();
    endtask

    always @(negedge clk) begin
        if (pend_valid) begin
            ba_q.push_back(busy);
            chk("valid_width", valid, 0);
        end
        pend_valid = valid;
        if (valid || frame_err) begin
            chk("valid_ferr_exclusive", valid & frame_err, 0);
            ev_q.push_back('{frame_err, data, busy});
        end
        if (!rst && !prev_rst && data !== prev_data) chk("data_changes_only_on_valid", valid, 1);
        prev_data = data;
        prev_rst  = rst;
    end

    initial begin
        logic [7:0] b;
        logic [8:0] m;
        logic [7:0] last_good;
        int         cpb;
        int         gap;
        logic       bad;

        tbl[0] = '{8'hA5, 16, 1'b1, 20, 1'b1, 8'hA5};
        tbl[1] = '{8'h3C, 16, 1'b1, 20, 1'b1, 8'h3C};
        tbl[2] = '{8'h81, 16, 1'b0, 40, 1'b0, 8'h3C};
        tbl[3] = '{8'h55, 16, 1'b1, 20, 1'b1, 8'h55};
        tbl[4] = '{8'h00, 16, 1'b1,  0, 1'b1, 8'h00};
        tbl[5] = '{8'hFF, 16, 1'b1, 20, 1'b1, 8'hFF};
        tbl[6] = '{8'hC3, 15, 1'b1, 20, 1'b1, 8'hC3};
        tbl[7] = '{8'hC3, 17, 1'b1, 20, 1'b1, 8'hC3};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.data", data, 8'h00);
        chk("reset.valid", valid, 0);
        chk("reset.frame_err", frame_err, 0);
        chk("reset.busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].b, tbl[i].cpb, tbl[i].stop, -1);
            if (!tbl[i].stop) begin
                rx = 1'b0;
                repeat (tbl[i].gap) @(posedge clk);
                #1;
                chk($sformatf("vec%0d.break_busy", i), busy, 1);
                idle(10);
                chk($sformatf("vec%0d.break_exit", i), busy, 0);
                idle(10);
            end else begin
                idle(tbl[i].gap);
            end
            check_frame($sformatf("vec%0d", i), tbl[i].good, tbl[i].exp_d);
        end

        // Short low glitch must be rejected at the start-bit centre.
        idle(10);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch.busy_rise", busy, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("glitch.busy_fall", busy, 0);
        idle(30);
        chk("glitch.events", ev_q.size(), 0);

        // Reset during data bit 3 abandons the frame and clears data.
        send_frame(8'hF8, 16, 1'b1, 4);
        idle(30);
        chk("midreset.events", ev_q.size(), 0);
        chk("midreset.data", data, 8'h00);
        chk("midreset.busy", busy, 0);
        ev_q.delete();
        ba_q.delete();
        send_frame(8'h7E, 16, 1'b1, -1);
        idle(30);
        check_frame("after_reset", 1'b1, 8'h7E);

        last_good = 8'h7E;
        for (int i = 0; i < 40; i++) begin
            b   = 8'($urandom);
            cpb = 15 + $urandom_range(0, 2);
            bad = (cpb == 16) && ($urandom_range(0, 5) == 0);
            gap = $urandom_range(20, 40);
            m   = model_frame(b, cpb, !bad, !bad);
            if (m[8]) last_good = m[7:0];
            send_frame(b, cpb, !bad, -1);
            if (bad) begin
                rx = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
                idle(20);
            end else begin
                idle(gap);
            end
            check_frame($sformatf("rand%0d", i), m[8], last_good);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
